wb_slave_regs: RTL and testbench

//  Wishbone classic (B4, non-pipelined) register-file slave that sits on one i2s_* port of
//  wb_intercon, downstream of the interconnect. It decodes a byte-address window, serves

---
 rtl/wb_slave_regs_if.sv | 26 ++
 rtl/wb_slave_regs.sv | 175 +++++++++++++++++
 tb/tb_wb_slave_regs.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/wb_slave_regs_if.sv
// Wishbone classic bus bundle between an interconnect port (master side)
// and the wb_slave_regs register-file slave.
interface wb_slave_regs_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [ADDR_WIDTH-1:0]     adr;
  logic [DATA_WIDTH-1:0]     dat_w;   // write data towards the slave (dat_i)
  logic [DATA_WIDTH/8-1:0]   sel;
  logic [DATA_WIDTH-1:0]     dat_r;   // read data from the slave (dat_o)
  logic                      ack;
  logic                      err;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_slave_regs.sv
// Wishbone classic (non-pipelined) register-file slave. Decodes a byte
// window of NUM_REGS words, serves single reads/writes after WAIT_CYCLES
// extra cycles, honours byte lanes on writes and terminates unmapped or
// misaligned accesses with err. All bus outputs are registered.
module wb_slave_regs #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 16'h1000,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_slave_regs_if.slave   bus
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam int IDXW   = $clog2(NUM_REGS);

  // Window bounds kept one bit wider so a window ending at the top of the
  // address space does not wrap.
  localparam logic [ADDR_WIDTH:0]   WIN_LO     = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   WIN_HI     = WIN_LO + (ADDR_WIDTH+1)'(NUM_REGS * NBYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Byte-lane merge: lanes with sel set take the new data, others keep old.
  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NBYTES-1:0]     lanes
  );
    logic [DATA_WIDTH-1:0] result;
    result = old_word;
    for (int b = 0; b < NBYTES; b++) begin
      if (lanes[b]) begin
        result[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        result[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return result;
  endfunction

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic                  we_q;
  logic [IDXW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [NBYTES-1:0]     sel_q;
  logic                  hit_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  req;
  logic                  hit_live;
  logic [ADDR_WIDTH:0]   adr_ext;
  logic                  enter_resp;
  logic                  cur_we;
  logic [IDXW-1:0]       cur_idx;
  logic [DATA_WIDTH-1:0] cur_dat;
  logic [NBYTES-1:0]     cur_sel;
  logic                  cur_hit;

  // Address decode of the live bus request.
  always_comb begin
    req      = bus.cyc & bus.stb;
    adr_ext  = {1'b0, bus.adr};
    hit_live = (adr_ext >= WIN_LO) && (adr_ext < WIN_HI) &&
               ((bus.adr & ALIGN_MASK) == {ADDR_WIDTH{1'b0}});
  end

  // Select the transfer being completed: live inputs when responding straight
  // from IDLE (no wait states), otherwise the values captured at the request.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_we  = bus.we;
      cur_idx = bus.adr[LSB +: IDXW];
      cur_dat = bus.dat_w;
      cur_sel = bus.sel;
      cur_hit = hit_live;
    end else begin
      cur_we  = we_q;
      cur_idx = idx_q;
      cur_dat = dat_q;
      cur_sel = sel_q;
      cur_hit = hit_q;
    end
    case (state)
      ST_IDLE: enter_resp = req && (WAIT_CYCLES == 0);
      ST_WAIT: enter_resp = req && (wait_cnt == 4'd0);
      default: enter_resp = 1'b0;
    endcase
  end

  // Transfer sequencing: capture request, count wait states, abort on stb drop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      idx_q    <= {IDXW{1'b0}};
      dat_q    <= {DATA_WIDTH{1'b0}};
      sel_q    <= {NBYTES{1'b0}};
      hit_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            we_q  <= bus.we;
            idx_q <= bus.adr[LSB +: IDXW];
            dat_q <= bus.dat_w;
            sel_q <= bus.sel;
            hit_q <= hit_live;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              wait_cnt <= WAIT_LOAD;
              state    <= ST_WAIT;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
          end else if (wait_cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response outputs: one-cycle ack/err pulse, read data only during a read ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.dat_r <= {DATA_WIDTH{1'b0}};
    end else begin
      bus.ack <= enter_resp & cur_hit;
      bus.err <= enter_resp & ~cur_hit;
      if (enter_resp && cur_hit && !cur_we) begin
        bus.dat_r <= regs[cur_idx];
      end else begin
        bus.dat_r <= {DATA_WIDTH{1'b0}};
      end
    end
  end

  // Register file: write commits on the edge entering RESP, hits only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (enter_resp && cur_hit && cur_we) begin
      regs[cur_idx] <= lane_merge(regs[cur_idx], cur_dat, cur_sel);
    end else begin
      regs[cur_idx] <= regs[cur_idx];
    end
  end

endmodule

// File: tb/tb_wb_slave_regs.sv
// Bench for wb_slave_regs: one instance with no wait states and one with
// three, driven through a shared set of stimulus variables, checked against
// a word-array model of the register window.
module tb_wb_slave_regs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_slave_regs_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus0 ();
  wb_slave_regs_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus3 ();

  wb_slave_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BASE_ADDR(16'h1000),
                  .NUM_REGS(8), .WAIT_CYCLES(0))
    dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  wb_slave_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BASE_ADDR(16'h1000),
                  .NUM_REGS(8), .WAIT_CYCLES(3))
    dut3 (.clk_i(clk), .rst_i(rst), .bus(bus3));

  // Shared drive; d_which selects which instance sees the request.
  logic        d_which = 1'b0;
  logic        d_cyc = 1'b0, d_stb = 1'b0, d_we = 1'b0;
  logic [15:0] d_adr = 16'h0;
  logic [31:0] d_dat = 32'h0;
  logic [3:0]  d_sel = 4'h0;

  assign bus0.cyc = d_cyc & ~d_which;
  assign bus3.cyc = d_cyc & d_which;
  assign bus0.stb = d_stb; assign bus3.stb = d_stb;
  assign bus0.we  = d_we;  assign bus3.we  = d_we;
  assign bus0.adr = d_adr; assign bus3.adr = d_adr;
  assign bus0.dat_w = d_dat; assign bus3.dat_w = d_dat;
  assign bus0.sel = d_sel; assign bus3.sel = d_sel;

  wire        o_ack = d_which ? bus3.ack   : bus0.ack;
  wire        o_err = d_which ? bus3.err   : bus0.err;
  wire [31:0] o_dat = d_which ? bus3.dat_r : bus0.dat_r;

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [2][8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input logic [15:0] a);
    return (a >= 16'h1000) && (a < 16'h1020) && ((a % 16'd4) == 16'd0);
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) mdl[d][i] = 32'h0;
  endtask

  // One complete transfer, checking quiet wait cycles, the response cycle
  // and that the response is exactly one cycle wide.
  task automatic xfer(input bit d, input bit we, input logic [15:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel);
    int w;
    int idx;
    bit hit;
    logic [31:0] exp_rd;
    logic [31:0] mask;
    w      = d ? 3 : 0;
    hit    = m_hit(adr);
    idx    = hit ? int'((adr - 16'h1000) / 16'd4) : 0;
    exp_rd = (hit && !we) ? mdl[d][idx] : 32'h0;
    @(negedge clk);
    d_which = d; d_cyc = 1'b1; d_stb = 1'b1; d_we = we;
    d_adr = adr; d_dat = dat; d_sel = sel;
    for (int n = 0; n <= w; n++) begin
      @(negedge clk);
      if (n < w) begin
        chk("wait_ack", {31'd0, o_ack}, 32'd0);
        chk("wait_err", {31'd0, o_err}, 32'd0);
      end else begin
        chk("resp_ack", {31'd0, o_ack}, {31'd0, hit});
        chk("resp_err", {31'd0, o_err}, {31'd0, !hit});
        if (!we || !hit) chk("resp_dat", o_dat, exp_rd);
        d_cyc = 1'b0; d_stb = 1'b0; d_dat = $urandom;
      end
    end
    @(negedge clk);
    chk("after_ack", {31'd0, o_ack}, 32'd0);
    chk("after_err", {31'd0, o_err}, 32'd0);
    chk("after_dat", o_dat, 32'd0);
    if (we && hit) begin
      mask = 32'h0;
      for (int b = 0; b < 4; b++) if (sel[b]) mask = mask + (32'hFF << (8 * b));
      mdl[d][idx] = (mdl[d][idx] & ~mask) | (dat & mask);
    end
  endtask

  task automatic read_all(input bit d);
    for (int i = 0; i < 8; i++) xfer(d, 1'b0, 16'h1000 + 16'(4 * i), 32'h0, 4'hF);
  endtask

  task automatic quiet(input bit d, input int n, input string tag);
    d_which = d;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_ack"}, {31'd0, o_ack}, 32'd0);
      chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
    end
  endtask

  initial begin
    clear_model();
    repeat (3) @(negedge clk);
    // reset state of both instances
    d_which = 1'b0;
    chk("rst0_ack", {31'd0, o_ack}, 32'd0);
    chk("rst0_err", {31'd0, o_err}, 32'd0);
    chk("rst0_dat", o_dat, 32'd0);
    d_which = 1'b1;
    chk("rst3_ack", {31'd0, o_ack}, 32'd0);
    chk("rst3_err", {31'd0, o_err}, 32'd0);
    chk("rst3_dat", o_dat, 32'd0);
    rst = 1'b0;

    // every register reads zero after reset
    read_all(1'b0);
    xfer(1'b0, 1'b0, 16'h1010, 32'h0, 4'h0);     // sel=0 read still acks

    // full write, read back, neighbour untouched
    xfer(1'b0, 1'b1, 16'h1004, 32'hDEADBEEF, 4'hF);
    xfer(1'b0, 1'b0, 16'h1004, 32'h0, 4'hF);
    xfer(1'b0, 1'b0, 16'h1000, 32'h0, 4'hF);

    // partial lanes
    xfer(1'b0, 1'b1, 16'h1004, 32'h11223344, 4'b0101);
    xfer(1'b0, 1'b0, 16'h1004, 32'h0, 4'hF);
    chk("lane_merge_model", mdl[0][1], 32'hDE22BE44);

    // error terminations leave storage alone
    xfer(1'b0, 1'b1, 16'h1020, 32'hFFFFFFFF, 4'hF);
    xfer(1'b0, 1'b1, 16'h1002, 32'hFFFFFFFF, 4'hF);
    xfer(1'b0, 1'b1, 16'h0000, 32'hFFFFFFFF, 4'hF);
    xfer(1'b0, 1'b0, 16'h101D, 32'h0, 4'hF);
    read_all(1'b0);

    // three wait states, then an aborted write
    xfer(1'b1, 1'b1, 16'h1008, 32'hCAFEF00D, 4'hF);
    xfer(1'b1, 1'b0, 16'h1008, 32'h0, 4'hF);
    @(negedge clk);
    d_which = 1'b1; d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1;
    d_adr = 16'h1008; d_dat = 32'h12345678; d_sel = 4'hF;
    @(negedge clk);
    d_stb = 1'b0; d_cyc = 1'b0;
    quiet(1'b1, 6, "abort");
    xfer(1'b1, 1'b0, 16'h1008, 32'h0, 4'hF);

    // randomized traffic on both instances
    for (int k = 0; k < 60; k++) begin
      xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'h0FF8 + 16'($urandom_range(0, 56)), $urandom, 4'($urandom_range(0, 15)));
    end
    read_all(1'b0);
    read_all(1'b1);

    // reset pulse while waiting
    @(negedge clk);
    d_which = 1'b1; d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1;
    d_adr = 16'h100C; d_dat = 32'hA5A5A5A5; d_sel = 4'hF;
    @(negedge clk);
    rst = 1'b1; d_stb = 1'b0; d_cyc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    quiet(1'b1, 5, "rst_wait");
    read_all(1'b1);
    read_all(1'b0);
    xfer(1'b1, 1'b1, 16'h101C, 32'h0BADF00D, 4'b1100);
    xfer(1'b1, 1'b0, 16'h101C, 32'h0, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
